// File: rtl/ps2_rx_fifo.sv
// PS/2 device->host receiver: input sync + deglitch, 11-bit frame deframing with
// parity/stop/timeout checks, and a show-ahead byte FIFO with a valid/ready read port.
module ps2_rx_fifo #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                             CLOCK_50,
  input  logic                             clr,
  input  logic                             PS2_CLK,
  input  logic                             PS2_DAT,
  output logic [7:0]                       q,
  output logic                             q_valid,
  input  logic                             q_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
  input  logic                             err_clr,
  output logic                             parity_err,
  output logic                             frame_err,
  output logic                             overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   filt_clk, fe;
  logic [FW-1:0]          filt_cnt;
  state_t                 state_q, state_d;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   parity_ok;
  logic [TW-1:0]          timer;
  logic                   push_c, perr_c, ferr_c, push_q;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr, rd_d;
  logic                   full_c, pop_c, push_ok_c, ovf_c;
  logic [CW-1:0]          count_d;
  logic [7:0]             head_d;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Pin synchronisers; idle PS/2 lines are high.
  always_ff @(posedge CLOCK_50) begin
    if (!clr) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  // Filtered clock follows clk_s only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLOCK_50) begin
    if (!clr) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
        fe       <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clr) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Frame FSM; an fe in the same cycle as the timeout wins.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    perr_c  = 1'b0;
    ferr_c  = 1'b0;
    if (fe) begin
      case (state_q)
        IDLE:    if (!dat_s) state_d = DATA;
        DATA:    if (bitcnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (!dat_s)         ferr_c = 1'b1;
          else if (parity_ok) push_c = 1'b1;
          else                perr_c = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timer == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      ferr_c  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clr) begin
      bitcnt    <= '0;
      shreg     <= '0;
      parity_ok <= 1'b0;
      push_q    <= 1'b0;
    end else begin
      push_q <= push_c;
      if (fe) begin
        case (state_q)
          IDLE:    bitcnt <= '0;
          DATA: begin
            shreg  <= {dat_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY:  parity_ok <= ^{shreg, dat_s};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clr || fe || state_q == IDLE) timer <= '0;
    else if (timer != TW'(TIMEOUT_CYCLES)) timer <= timer + TW'(1);
  end

  // FIFO next-state; head_d bypasses the write when the new byte becomes the head.
  always_comb begin
    full_c    = (count == CW'(FIFO_DEPTH));
    pop_c     = q_valid && q_ready;
    push_ok_c = push_q && (!full_c || pop_c);
    ovf_c     = push_q && full_c && !pop_c;
    rd_d      = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    case ({push_ok_c, pop_c})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
    head_d = (push_ok_c && wr_ptr == rd_d) ? shreg : mem[rd_d];
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok_c) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_d;
      count   <= count_d;
      q_valid <= (count_d != '0);
      q       <= (count_d != '0) ? head_d : 8'h00;
    end
  end

  // Sticky flags: a set event beats err_clr in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!clr) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= perr_c | (parity_err & ~err_clr);
      frame_err  <= ferr_c | (frame_err & ~err_clr);
      overflow   <= ovf_c  | (overflow & ~err_clr);
    end
  end

endmodule
